// File: rtl/stream_arbiter_if.sv
// Valid/ready stream carrying one payload word of type T per transfer.
// Latency: none, this is wiring only.
// Backpressure: a word moves on a rising edge where valid && ready; the producer holds it until then.
// Modports: send/master (drives valid and data) and receive/slave (drives ready).
interface stream #(
  parameter type T = logic [7:0]
) ();
  logic valid;
  logic ready;
  T     data;

  modport send    (output valid, output data, input ready);
  modport receive (input valid, input data, output ready);
  modport master  (output valid, output data, input ready);
  modport slave   (input valid, input data, output ready);
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin merge of COUNT input streams into one registered output stream, with the source index carried alongside.
// Latency: one cycle. A word accepted at edge N is on sender right after N. Full rate is one word per cycle.
// Backpressure: a held, unaccepted output word drops every input ready and freezes the output register.
// Ports: clock, reset (synchronous, active-low); receivers[COUNT] inputs; sender output; sender_index (valid while sender.valid).
module stream_arbiter #(
  parameter type T     = logic [7:0],
  parameter int  COUNT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  stream.receive                     receivers [COUNT],
  stream.send                        sender,
  output logic [$clog2(COUNT)-1:0]   sender_index
);

  localparam int IW = $clog2(COUNT);
  typedef logic [IW-1:0] index;

  logic in_valid [COUNT];
  T     in_data  [COUNT];
  logic in_ready [COUNT];

  // Interface arrays only accept constant subscripts, so flatten them here.
  for (genvar g = 0; g < COUNT; g++) begin : g_flat
    assign in_valid[g]     = receivers[g].valid;
    assign in_data[g]      = receivers[g].data;
    assign receivers[g].ready = in_ready[g];
  end

  logic out_valid;
  T     out_data;
  index out_index;
  index prio;

  logic load;
  logic grant_valid;
  index grant;

  // The output register can take a new word when it is empty or its word leaves this cycle.
  assign load = !out_valid || sender.ready;

  // Search from prio upward first, then wrap to the indices below prio.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (!grant_valid && in_valid[i] && (index'(i) >= prio)) begin
        grant_valid = 1'b1;
        grant       = index'(i);
      end
    end
    for (int i = 0; i < COUNT; i++) begin
      if (!grant_valid && in_valid[i] && (index'(i) < prio)) begin
        grant_valid = 1'b1;
        grant       = index'(i);
      end
    end
  end

  // Reset gates ready so nothing is acknowledged in a reset cycle.
  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      in_ready[i] = 1'b0;
    end
    for (int i = 0; i < COUNT; i++) begin
      in_ready[i] = reset && load && grant_valid && (grant == index'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      prio      <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        prio <= (grant == index'(COUNT - 1)) ? '0 : index'(grant + 1'b1);
      end
    end
  end

  // Payload and index need no reset; they are only meaningful while out_valid is set.
  always_ff @(posedge clock) begin
    if (load && grant_valid) begin
      out_data  <= in_data[grant];
      out_index <= grant;
    end
  end

  assign sender.valid = out_valid;
  assign sender.data  = out_data;
  assign sender_index = out_index;

endmodule
